// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared state encoding for the word serializer
package word_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/word_serializer_if.sv
// rtl/word_serializer_if.sv - load and serial handshake bundle
interface word_serializer_if #(
    parameter int SELECT_WIDTH = 3
);
    logic                         load_valid;
    logic                         load_ready;
    logic [2**SELECT_WIDTH-1:0]   load_data;
    logic                         ser_valid;
    logic                         ser_ready;
    logic                         ser_bit;
    logic                         ser_last;
    logic [SELECT_WIDTH-1:0]      bit_idx;

    // Producer/consumer side that drives words in and takes bits out
    modport master (
        output load_valid,
        output load_data,
        output ser_ready,
        input  load_ready,
        input  ser_valid,
        input  ser_bit,
        input  ser_last,
        input  bit_idx
    );

    // Serializer side
    modport slave (
        input  load_valid,
        input  load_data,
        input  ser_ready,
        output load_ready,
        output ser_valid,
        output ser_bit,
        output ser_last,
        output bit_idx
    );
endinterface

// File: rtl/word_serializer_nbit_mux.sv
// rtl/word_serializer_nbit_mux.sv - 2**SELECT_WIDTH to 1 bit multiplexer
module nbit_mux #(
    parameter int SELECT_WIDTH = 3
) (
    input  logic [2**SELECT_WIDTH-1:0] mux_in,
    input  logic [SELECT_WIDTH-1:0]    mux_sel,
    output logic                       mux_out
);

    assign mux_out = mux_in[mux_sel];

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel word to serial bit stream with valid/ready handshakes
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int SELECT_WIDTH = 3,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    word_serializer_if.slave bus
);

    localparam int W = 2**SELECT_WIDTH;
    localparam logic [SELECT_WIDTH-1:0] LAST_CNT = SELECT_WIDTH'(W - 1);

    state_t                  state;
    state_t                  state_next;
    logic [W-1:0]            word_q;
    logic [SELECT_WIDTH-1:0] count_q;

    logic                    shifting;
    logic                    last;
    logic                    beat;
    logic                    load_ready;
    logic                    load_fire;
    logic [SELECT_WIDTH-1:0] idx;
    logic                    mux_out;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: flush always wins, a final beat without a reload drops back to idle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (load_fire) state_next = ST_SHIFT;
            ST_SHIFT: if (beat && last && !load_fire) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // Handshake and presentation outputs derived from state and count
    always_comb begin
        shifting   = (state == ST_SHIFT);
        last       = shifting && (count_q == LAST_CNT);
        beat       = shifting && bus.ser_ready;
        load_ready = !flush && (!shifting || (last && bus.ser_ready));
        load_fire  = bus.load_valid && load_ready;
        idx        = '0;
        if (shifting) idx = MSB_FIRST ? (LAST_CNT - count_q) : count_q;
    end

    // Word register and beat counter; a reload restarts the count without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (load_fire) begin
            word_q  <= bus.load_data;
            count_q <= '0;
        end else if (beat && !last) begin
            count_q <= count_q + 1'b1;
        end
    end

    nbit_mux #(
        .SELECT_WIDTH (SELECT_WIDTH)
    ) u_mux (
        .mux_in  (word_q),
        .mux_sel (idx),
        .mux_out (mux_out)
    );

    assign bus.load_ready = load_ready;
    assign bus.ser_valid  = shifting;
    assign bus.ser_last   = last;
    assign bus.bit_idx    = idx;
    assign bus.ser_bit    = mux_out;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - directed self-checking bench for word_serializer, LSB- and MSB-first
module tb_word_serializer;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       lv;
    logic [7:0] ld;
    logic       sr;

    int checks;
    int errors;

    word_serializer_if #(.SELECT_WIDTH(3)) ifl ();
    word_serializer_if #(.SELECT_WIDTH(3)) ifm ();

    assign ifl.load_valid = lv;
    assign ifl.load_data  = ld;
    assign ifl.ser_ready  = sr;
    assign ifm.load_valid = lv;
    assign ifm.load_data  = ld;
    assign ifm.ser_ready  = sr;

    word_serializer #(.SELECT_WIDTH(3), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (ifl.slave)
    );

    word_serializer #(.SELECT_WIDTH(3), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (ifm.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected presentation of beat k of word w on both instances
    task automatic check_beat(input int k, input logic [7:0] w);
        check("lsb_valid", 32'(ifl.ser_valid), 32'd1);
        check("lsb_bit",   32'(ifl.ser_bit),   32'(w[k]));
        check("lsb_idx",   32'(ifl.bit_idx),   32'(k));
        check("lsb_last",  32'(ifl.ser_last),  32'(k == 7));
        check("msb_valid", 32'(ifm.ser_valid), 32'd1);
        check("msb_bit",   32'(ifm.ser_bit),   32'(w[7-k]));
        check("msb_idx",   32'(ifm.bit_idx),   32'(7 - k));
        check("msb_last",  32'(ifm.ser_last),  32'(k == 7));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_lsb_valid"}, 32'(ifl.ser_valid),  32'd0);
        check({tag, "_msb_valid"}, 32'(ifm.ser_valid),  32'd0);
        check({tag, "_lsb_ready"}, 32'(ifl.load_ready), 32'd1);
        check({tag, "_msb_idx"},   32'(ifm.bit_idx),    32'd0);
    endtask

    // Present w until accepted; returns one cycle after acceptance with load_valid low
    task automatic load_word(input logic [7:0] w);
        bit taken;
        taken = 1'b0;
        lv = 1'b1;
        ld = w;
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            taken = ifl.load_ready && ifm.load_ready;
            next_cycle();
        end
        check("load_taken", 32'(taken), 32'd1);
        lv = 1'b0;
    endtask

    // Collect 8 beats, optionally with random backpressure; stalls must hold the same beat
    task automatic serialize(input logic [7:0] w, input bit rnd);
        int n;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
            sr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            check_beat(n, w);
            check("beat_load_ready", 32'(ifl.load_ready), 32'(n == 7 && sr));
            if (sr) n++;
            next_cycle();
        end
        check("beat_count", 32'(n), 32'd8);
        sr = 1'b1;
        @(negedge clk);
        check_idle("after_word");
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        lv     = 1'b0;
        ld     = 8'h00;
        sr     = 1'b1;

        // Reset values
        #3;
        check_idle("reset");
        check("reset_lsb_last", 32'(ifl.ser_last), 32'd0);
        check("reset_lsb_bit",  32'(ifl.ser_bit),  32'd0);
        check("reset_lsb_idx",  32'(ifl.bit_idx),  32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // LSB/MSB-first single words, full-rate consumer
        load_word(8'hA5);
        serialize(8'hA5, 1'b0);
        load_word(8'h01);
        serialize(8'h01, 1'b0);

        // Random backpressure
        load_word(8'h3C);
        serialize(8'h3C, 1'b1);
        load_word(8'h96);
        serialize(8'h96, 1'b1);

        // Zero-bubble streaming of two words
        lv = 1'b1;
        ld = 8'h0F;
        sr = 1'b1;
        @(negedge clk);
        check("stream_first_ready", 32'(ifl.load_ready), 32'd1);
        next_cycle();
        ld = 8'hF0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_beat(k % 8, (k < 8) ? 8'h0F : 8'hF0);
            check("stream_load_ready", 32'(ifl.load_ready), 32'(k % 8 == 7));
            next_cycle();
            if (k == 7) lv = 1'b0;
        end
        @(negedge clk);
        check_idle("stream_end");
        next_cycle();

        // Flush on beat 3 with a competing load
        load_word(8'hFF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_beat(k, 8'hFF);
            next_cycle();
        end
        flush = 1'b1;
        lv    = 1'b1;
        ld    = 8'hAA;
        @(negedge clk);
        check("flush_lsb_ready", 32'(ifl.load_ready), 32'd0);
        check("flush_msb_ready", 32'(ifm.load_ready), 32'd0);
        next_cycle();
        flush = 1'b0;
        lv    = 1'b0;
        @(negedge clk);
        check_idle("post_flush");
        next_cycle();
        @(negedge clk);
        check_idle("post_flush2");
        next_cycle();
        load_word(8'h00);
        serialize(8'h00, 1'b0);

        // Asynchronous reset in the middle of a word
        load_word(8'h5A);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_beat(k, 8'h5A);
            next_cycle();
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_lsb_idx", 32'(ifl.bit_idx), 32'd0);
        check("async_reset_last",    32'(ifl.ser_last), 32'd0);
        check("async_reset_bit",     32'(ifl.ser_bit), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle("after_reset");
            next_cycle();
        end
        load_word(8'hC3);
        serialize(8'hC3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
